// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with optional
// write-to-read bypass, asynchronous array reset and a per-register busy
// scoreboard with a registered busy count. Register 0 is hard-wired to zero.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            regWrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  output logic            busy1,
  output logic            busy2,
  input  logic            reserve,
  input  logic [AW-1:0]   rd_res,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            wr_en, res_en, inc, dec;

  // Register 0 is never written nor reserved.
  assign wr_en  = regWrite && (rd != '0);
  assign res_en = reserve && (rd_res != '0);

  // Scoreboard next state: release on write, then reserve overrides.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[rd]     = 1'b0;
    if (res_en) busy_d[rd_res] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy count tracks set/clear transitions so it never wraps.
  always_comb begin
    inc   = res_en && !busy_q[rd_res];
    dec   = wr_en && busy_q[rd] && !(res_en && (rd_res == rd));
    cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  // Register array with asynchronous clear of every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= data;
    end
  end

  // Scoreboard bits and busy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read port 1; bypass blocked while in reset so reset dominates.
  always_comb begin
    rv1   = regs_q[rs1];
    busy1 = busy_q[rs1];
    if (BYPASS && rst_n && wr_en && (rd == rs1)) begin
      rv1   = data;
      busy1 = 1'b0;
    end
  end

  // Read port 2; same forwarding rule as port 1.
  always_comb begin
    rv2   = regs_q[rs2];
    busy2 = busy_q[rs2];
    if (BYPASS && rst_n && wr_en && (rd == rs2)) begin
      rv2   = data;
      busy2 = 1'b0;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a bypassing and a non-bypassing
// instance share stimulus and are checked against an array-based model.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            regWrite, reserve;
  logic [AW-1:0]   rd, rs1, rs2, rd_res;
  logic [XLEN-1:0] data;

  logic [XLEN-1:0] rv1_b, rv2_b, rv1_n, rv2_n;
  logic            busy1_b, busy2_b, busy1_n, busy2_n;
  logic [AW:0]     cnt_b, cnt_n;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .rd(rd), .data(data),
    .rs1(rs1), .rs2(rs2), .rv1(rv1_b), .rv2(rv2_b), .busy1(busy1_b),
    .busy2(busy2_b), .reserve(reserve), .rd_res(rd_res), .busy_cnt(cnt_b)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .rd(rd), .data(data),
    .rs1(rs1), .rs2(rs2), .rv1(rv1_n), .rv2(rv2_n), .busy1(busy1_n),
    .busy2(busy2_n), .reserve(reserve), .rd_res(rd_res), .busy_cnt(cnt_n)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Expected read value/busy for one port, given current inputs.
  task automatic exp_read(input logic [AW-1:0] rs, input bit byp,
                          output logic [XLEN-1:0] v, output logic b);
    if (rs == 0) begin
      v = '0;
      b = 1'b0;
    end else if (byp && rst_n && regWrite && rd == rs) begin
      v = data;
      b = 1'b0;
    end else begin
      v = m_regs[rs];
      b = m_busy[rs];
    end
  endtask

  task automatic check_all(input string tag);
    logic [XLEN-1:0] v;
    logic b;
    exp_read(rs1, 1'b1, v, b);
    chk({tag, ".b.rv1"}, rv1_b, v);
    chk({tag, ".b.busy1"}, {31'd0, busy1_b}, {31'd0, b});
    exp_read(rs2, 1'b1, v, b);
    chk({tag, ".b.rv2"}, rv2_b, v);
    chk({tag, ".b.busy2"}, {31'd0, busy2_b}, {31'd0, b});
    exp_read(rs1, 1'b0, v, b);
    chk({tag, ".n.rv1"}, rv1_n, v);
    chk({tag, ".n.busy1"}, {31'd0, busy1_n}, {31'd0, b});
    exp_read(rs2, 1'b0, v, b);
    chk({tag, ".n.rv2"}, rv2_n, v);
    chk({tag, ".n.busy2"}, {31'd0, busy2_n}, {31'd0, b});
    chk({tag, ".b.cnt"}, {26'd0, cnt_b}, model_cnt());
    chk({tag, ".n.cnt"}, {26'd0, cnt_n}, model_cnt());
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] d_rd, input logic [XLEN-1:0] d,
                       input logic res, input logic [AW-1:0] d_res,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    regWrite = we; rd = d_rd; data = d; reserve = res; rd_res = d_res;
    rs1 = r1; rs2 = r2;
    #1;
  endtask

  // Clock edge, then apply the specification's update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (regWrite && rd != 0) begin
        m_regs[rd] = data;
        m_busy[rd] = 1'b0;
      end
      if (reserve && rd_res != 0) m_busy[rd_res] = 1'b1;
    end
    #1;
  endtask

  task automatic step(input string tag);
    check_all({tag, ".pre"});
    tick();
    check_all({tag, ".post"});
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, rs1, rs2);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd2);
    check_all("reset");
    chk("reset.cnt_const", {26'd0, cnt_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-operation: clears immediately, no edge needed.
    drive(1'b1, 5'd6, 32'h38, 1'b1, 5'd9, 5'd1, 5'd6);
    step("wr_x6");
    idle();
    chk("x6_written", rv2_b, 32'h38);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.rv2", rv2_b, 32'h0);
    chk("async_rst.rv2_nb", rv2_n, 32'h0);
    chk("async_rst.cnt", {26'd0, cnt_b}, 32'd0);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic write with bypass vs. no bypass.
    drive(1'b1, 5'd5, 32'd28, 1'b0, '0, 5'd5, 5'd5);
    chk("bypass.rv1", rv1_b, 32'h1C);
    chk("nobypass.rv1_pre", rv1_n, 32'h0);
    step("wr_x5");
    chk("nobypass.rv1_post", rv1_n, 32'h1C);

    // Write disabled across three edges.
    drive(1'b0, 5'd5, 32'd34, 1'b0, '0, 5'd5, 5'd0);
    for (int i = 0; i < 3; i++) step("wr_dis");
    chk("wr_dis.rv1", rv1_b, 32'h1C);

    // x0 protection.
    drive(1'b1, 5'd0, 32'd34, 1'b1, 5'd0, 5'd0, 5'd0);
    step("x0");
    chk("x0.rv1", rv1_b, 32'h0);
    chk("x0.cnt", {26'd0, cnt_b}, 32'd0);

    // Scoreboard: reserve, re-reserve, release by write.
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd7);
    step("res_x7");
    chk("res_x7.busy1", {31'd0, busy1_b}, 32'd1);
    chk("res_x7.cnt", {26'd0, cnt_b}, 32'd1);
    step("res_x7_again");
    chk("res_x7_again.cnt", {26'd0, cnt_b}, 32'd1);
    drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0, 5'd7, 5'd7);
    step("wr_x7");
    idle();
    chk("wr_x7.rv1", rv1_b, 32'hDEADBEEF);
    chk("wr_x7.busy1", {31'd0, busy1_b}, 32'd0);
    chk("wr_x7.cnt", {26'd0, cnt_b}, 32'd0);

    // Simultaneous reserve and write to same busy register.
    drive(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd4);
    step("res_x3");
    drive(1'b1, 5'd3, 32'd9, 1'b1, 5'd3, 5'd3, 5'd4);
    chk("same.busy1_byp", {31'd0, busy1_b}, 32'd0);
    step("same_x3");
    idle();
    chk("same.rv1", rv1_b, 32'd9);
    chk("same.busy1", {31'd0, busy1_b}, 32'd1);
    chk("same.cnt", {26'd0, cnt_b}, 32'd1);

    // Reserve x4 while releasing x3.
    drive(1'b1, 5'd3, 32'd11, 1'b1, 5'd4, 5'd3, 5'd4);
    step("swap");
    chk("swap.cnt", {26'd0, cnt_b}, 32'd1);

    // Reserve every register: count saturates at NREG-1.
    for (int i = 1; i < NREG; i++) begin
      drive(1'b0, '0, '0, 1'b1, i[AW-1:0], i[AW-1:0], 5'd0);
      step("res_all");
    end
    chk("res_all.cnt", {26'd0, cnt_b}, 32'd31);
    drive(1'b0, '0, '0, 1'b1, 5'd12, 5'd12, 5'd0);
    step("res_full");
    chk("res_full.cnt", {26'd0, cnt_b}, 32'd31);

    // Randomized traffic against the model, with occasional async reset.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] r_rd;
      r_rd = AW'($urandom_range(0, NREG - 1));
      drive(1'($urandom_range(0, 1)), r_rd, $urandom(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? r_rd : AW'($urandom_range(0, NREG - 1)),
            ($urandom_range(0, 2) == 0) ? r_rd : AW'($urandom_range(0, NREG - 1)),
            AW'($urandom_range(0, NREG - 1)));
      if ($urandom_range(0, 99) == 0) begin
        regWrite = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
      end else begin
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
